// File: rtl/vr16_pkg.sv
// Shared VR16 definitions: datapath width, opcodes and the fetch FSM state encoding.
package vr16_pkg;

  localparam int unsigned VR16_XLEN = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order FIFO with flush; entry 0 is always the head so outputs come from registers.
module fetch_skid_fifo #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] slot0_q, slot1_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      case ({wr_en_i, rd_en_i})
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_q <= wr_data_i;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            slot1_q <= wr_data_i;
            count_q <= 2'd2;
          end
        end
        2'b11: begin
          // Simultaneous push and pop keeps the count; the new word lands behind any survivor.
          if (count_q == 2'd1) begin
            slot0_q <= wr_data_i;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= wr_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = slot0_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// VR16 fetch stage: owns the PC, drives instruction memory and feeds decode through a skid buffer.
module fetch_controller
  import vr16_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = OP_HALT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 imem_enable,
  output logic [VR16_XLEN-1:0] imem_address,
  input  logic [VR16_XLEN-1:0] imem_instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [VR16_XLEN-1:0] instr,
  output logic [VR16_XLEN-1:0] instr_pc,
  input  logic                 redirect_valid,
  input  logic [VR16_XLEN-1:0] redirect_pc,
  output logic                 halted
);

  localparam logic [VR16_XLEN-1:0] PcMask = VR16_XLEN'(IMEM_DEPTH - 1);

  fetch_state_e         state_q;
  logic [VR16_XLEN-1:0] pc_q, resp_pc_q;
  logic                 inflight_q;

  logic [1:0]             buf_count, occupancy;
  logic                   pop, redir, halt_pop, issue, buf_wr, buf_flush;
  logic [2*VR16_XLEN-1:0] buf_head;

  always_comb begin
    pop       = instr_valid & instr_ready;
    redir     = redirect_valid & (state_q != StIdle);
    halt_pop  = (state_q == StFetch) & pop & (instr[15:12] == HALT_OPCODE) & ~redir;
    occupancy = buf_count + 2'(inflight_q);
    issue     = (state_q == StFetch) & ~redir &
                ((occupancy < 2'd2) | ((occupancy == 2'd2) & pop));
    // A response is only kept while still fetching and nothing squashed it this cycle.
    buf_wr    = inflight_q & (state_q == StFetch) & ~redir & ~halt_pop;
    buf_flush = redir | halt_pop;
  end

  assign imem_enable  = issue;
  assign imem_address = issue ? pc_q : '0;
  assign halted       = (state_q == StHalted);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        resp_pc_q <= pc_q;
        pc_q      <= (pc_q + 16'd1) & PcMask;
      end
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StFetch;
        end
        StFetch: begin
          if (redir) begin
            pc_q <= redirect_pc & PcMask;
          end else if (halt_pop) begin
            state_q <= StHalted;
          end
        end
        StHalted: begin
          if (redir) begin
            state_q <= StFetch;
            pc_q    <= redirect_pc & PcMask;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fetch_skid_fifo #(
    .Width(2 * VR16_XLEN)
  ) u_skid (
    .clk_i    (clk),
    .rst_i    (reset),
    .flush_i  (buf_flush),
    .wr_en_i  (buf_wr),
    .wr_data_i({resp_pc_q, imem_instr}),
    .rd_en_i  (pop),
    .valid_o  (instr_valid),
    .data_o   (buf_head),
    .count_o  (buf_count)
  );

  assign {instr_pc, instr} = buf_head;

endmodule
